// File: rtl/mux4_rr_arbiter_if.sv
// Bundle of the request/data/grant signals shared between four producers
// and the round-robin arbiter that owns the single output path.
interface mux4_rr_arbiter_if #(
    parameter int DW = 8
);
    logic [3:0]    req;
    logic [DW-1:0] in0;
    logic [DW-1:0] in1;
    logic [DW-1:0] in2;
    logic [DW-1:0] in3;
    logic [3:0]    gnt;
    logic          sel1;
    logic          sel0;
    logic [DW-1:0] out;
    logic          out_valid;

    // Producer side: raises requests, presents data, observes the grant
    modport master (
        output req, in0, in1, in2, in3,
        input  gnt, sel1, sel0, out, out_valid
    );

    // Arbiter side
    modport slave (
        input  req, in0, in1, in2, in3,
        output gnt, sel1, sel0, out, out_valid
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 data mux. One owner at a time,
// with a hold limit that forces a handover when someone else is waiting.
module mux4_rr_arbiter #(
    parameter int DW       = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mux4_rr_arbiter_if.slave  bus
);
    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [1:0]  owner_reg, owner_next;
    logic [1:0]  last_reg, last_next;
    logic [3:0]  hold_cnt_reg, hold_cnt_next;
    logic [3:0]  gnt_reg;
    logic        valid_reg;

    // Requests rotated so that bit 0 is the index right after the last grant;
    // the last-granted index itself lands in bit 3 (lowest priority).
    logic [3:0]  req_rot;
    logic [1:0]  pick_ofs;
    logic [1:0]  pick;
    logic [3:0]  owner_onehot;
    logic        others_waiting;

    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
        assign req_rot[gi] = bus.req[2'(last_reg + 2'(gi + 1))];
    end

    // First asserted position in rotated order wins
    always_comb begin
        pick_ofs = 2'd0;
        if (req_rot[0])      pick_ofs = 2'd0;
        else if (req_rot[1]) pick_ofs = 2'd1;
        else if (req_rot[2]) pick_ofs = 2'd2;
        else if (req_rot[3]) pick_ofs = 2'd3;
    end

    assign pick           = 2'(last_reg + 2'd1 + pick_ofs);
    assign owner_onehot   = 4'b0001 << owner_reg;
    assign others_waiting = |(bus.req & ~owner_onehot);

    // Next-state: release first, then forced switch, otherwise keep owner
    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        last_next     = last_reg;
        hold_cnt_next = hold_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (|bus.req) begin
                    state_next    = GRANT;
                    owner_next    = pick;
                    last_next     = pick;
                    hold_cnt_next = 4'd0;
                end
            end
            GRANT: begin
                if (!bus.req[owner_reg]) begin
                    hold_cnt_next = 4'd0;
                    if (others_waiting) begin
                        owner_next = pick;
                        last_next  = pick;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (hold_cnt_reg == HOLD_LAST && others_waiting) begin
                    // last == owner here, so the pick skips the current owner
                    owner_next    = pick;
                    last_next     = pick;
                    hold_cnt_next = 4'd0;
                end else if (hold_cnt_reg != HOLD_LAST) begin
                    hold_cnt_next = hold_cnt_reg + 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and registered outputs, all updated from the same next values
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            owner_reg    <= 2'd0;
            last_reg     <= 2'd3;
            hold_cnt_reg <= 4'd0;
            gnt_reg      <= 4'b0000;
            valid_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            last_reg     <= last_next;
            hold_cnt_reg <= hold_cnt_next;
            gnt_reg      <= (state_next == GRANT) ? (4'b0001 << owner_next) : 4'b0000;
            valid_reg    <= (state_next == GRANT);
        end
    end

    assign bus.gnt       = gnt_reg;
    assign bus.sel1      = owner_reg[1];
    assign bus.sel0      = owner_reg[0];
    assign bus.out_valid = valid_reg;

    // Zero-latency data path from the registered select, forced to 0 when idle
    always_comb begin
        bus.out = '0;
        if (valid_reg) begin
            case (owner_reg)
                2'd0: bus.out = bus.in0;
                2'd1: bus.out = bus.in1;
                2'd2: bus.out = bus.in2;
                2'd3: bus.out = bus.in3;
            endcase
        end
    end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Randomized and directed stimulus for mux4_rr_arbiter, checked each cycle
// against a behavioural model of the arbitration rules.
module tb_mux4_rr_arbiter;
    localparam int DW       = 8;
    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst_n;

    mux4_rr_arbiter_if #(.DW(DW)) bus ();

    mux4_rr_arbiter #(.DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: who owns the path, who was granted last, and for how many
    // consecutive cycles the current owner has been holding it.
    bit         m_init   = 0;
    bit         m_active = 0;
    int         m_owner  = 0;
    int         m_last   = 3;
    int         m_held   = 0;
    logic [DW-1:0] ins [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++)
            if (r[(last + k) % 4]) return (last + k) % 4;
        return 0;
    endfunction

    // Advance the model by one rising edge that samples r / rn
    task automatic model_step(input logic [3:0] r, input bit rn);
        bit others;
        if (!rn) begin
            m_active = 0; m_owner = 0; m_last = 3; m_held = 0;
            return;
        end
        if (!m_active) begin
            if (r != 0) begin
                m_owner = rr_pick(r, m_last);
                m_last = m_owner; m_held = 1; m_active = 1;
            end
            return;
        end
        others = 0;
        for (int i = 0; i < 4; i++) if (i != m_owner && r[i]) others = 1;
        if (!r[m_owner]) begin
            if (others) begin
                m_owner = rr_pick(r, m_last); m_last = m_owner; m_held = 1;
            end else begin
                m_active = 0;
            end
        end else if (m_held >= MAX_HOLD && others) begin
            m_owner = rr_pick(r, m_last); m_last = m_owner; m_held = 1;
        end else begin
            m_held++;
        end
    endtask

    // One clock: check registered outputs, drive new inputs, check the mux
    task automatic cycle(input logic [3:0] r, input bit rn);
        @(negedge clk);
        if (m_init) begin
            check("gnt", 32'(bus.gnt), m_active ? (32'd1 << m_owner) : 32'd0);
            check("out_valid", 32'(bus.out_valid), 32'(m_active));
            if (m_active) check("sel", 32'({bus.sel1, bus.sel0}), 32'(m_owner));
        end
        bus.req = r;
        rst_n   = rn;
        for (int i = 0; i < 4; i++) ins[i] = DW'($urandom);
        bus.in0 = ins[0]; bus.in1 = ins[1]; bus.in2 = ins[2]; bus.in3 = ins[3];
        #1;
        if (m_init) check("out", 32'(bus.out), m_active ? 32'(ins[m_owner]) : 32'd0);
        model_step(r, rn);
        m_init = 1;
    endtask

    initial begin
        logic [3:0] r;
        rst_n = 1'b0;
        bus.req = 4'b1111;
        bus.in0 = '0; bus.in1 = '0; bus.in2 = '0; bus.in3 = '0;

        // Reset with all requests high, then release: round robin 0,1,2,3,0
        cycle(4'b1111, 0);
        cycle(4'b1111, 0);
        cycle(4'b1111, 1);
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_sel", 32'({bus.sel1, bus.sel0}), 32'd0);
        check("rst_out", 32'(bus.out), 32'd0);
        cycle(4'b1111, 1);
        check("first_gnt", 32'(bus.gnt), 32'b0001);
        repeat (18) cycle(4'b1111, 1);

        // Single requester keeps the grant past the hold limit, then drops
        cycle(4'b0000, 0);
        repeat (10) cycle(4'b0100, 1);
        check("solo_gnt", 32'(bus.gnt), 32'b0100);
        cycle(4'b0000, 1);
        cycle(4'b0000, 1);
        check("solo_idle_out", 32'(bus.out), 32'd0);

        // Early release handover: owner 1 leaves while 3 waits
        cycle(4'b0000, 0);
        cycle(4'b0010, 1);
        cycle(4'b1010, 1);
        cycle(4'b1000, 1);
        cycle(4'b1001, 1);
        check("handover_gnt", 32'(bus.gnt), 32'b1000);
        repeat (6) cycle(4'b1001, 1);

        // Wrap and skip: last = 2, then requests 0 and 1
        cycle(4'b0000, 0);
        cycle(4'b0100, 1);
        cycle(4'b0011, 1);
        cycle(4'b0011, 1);
        check("wrap_gnt", 32'(bus.gnt), 32'b0001);
        repeat (6) cycle(4'b0011, 1);

        // Mid-grant reset drops the grant; requester 0 regains priority
        cycle(4'b0000, 0);
        cycle(4'b0100, 1);
        cycle(4'b0101, 1);
        cycle(4'b0101, 0);
        cycle(4'b0101, 1);
        check("midrst_gnt", 32'(bus.gnt), 32'd0);
        cycle(4'b0101, 1);
        check("midrst_prio", 32'(bus.gnt), 32'b0001);

        // Random traffic with sticky requests and occasional resets
        r = 4'($urandom);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            cycle(r, $urandom_range(0, 99) != 0);
        end
        cycle(4'b0000, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
